tick_scheduler: RTL and testbench

Multi-channel software-timer scheduler driven by the 1 µs tick pulse of the game's tick timer. It shares a single decrement datapath among NCH channels by sweeping them sequentially after every tick. Each channel is either one-shot or periodic, and raises a one-cycle expiry strobe. Consumers include alien march cadence, shot travel, UFO spawn and sound-note durations.

---
 rtl/tick_scheduler.sv | 131 +++++++++++++
 tb/tb_tick_scheduler.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_scheduler.sv
// tick_scheduler: NCH software timers that share one decrement datapath, swept channel by channel after each trigger.
// Build option TICK_SCHED_MS_EN: prescale i_tick by 1000 so periods are in milliseconds instead of microseconds.

module tick_scheduler #(
  parameter int NCH = 4,
  parameter int CW  = 16,
  parameter int CHW = $clog2(NCH)
) (
  input  logic           i_clk_25MHz,
  input  logic           i_reset,
  input  logic           i_tick,
  input  logic           i_cfg_we,
  input  logic [CHW-1:0] i_cfg_ch,
  input  logic [CW-1:0]  i_cfg_period,
  input  logic           i_cfg_periodic,
  output logic           o_cfg_ready,
  output logic [NCH-1:0] o_expire,
  output logic           o_busy,
  output logic           o_overrun
);

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  state_t         state_reg;
  logic [CHW-1:0] idx_reg;
  logic           trigger;
  logic           cfg_accept;
  logic           sweep_last;
  logic [NCH-1:0] expire_hit;

`ifdef TICK_SCHED_MS_EN
  logic [9:0] presc_reg;

  // Prescaler keeps counting i_tick even while a sweep is running.
  always_ff @(posedge i_clk_25MHz) begin
    if (!i_reset) begin
      presc_reg <= 10'd0;
    end else if (i_tick) begin
      presc_reg <= (presc_reg == 10'd999) ? 10'd0 : presc_reg + 10'd1;
    end
  end

  assign trigger = i_tick && (presc_reg == 10'd999);
`else
  assign trigger = i_tick;
`endif

  assign cfg_accept = i_cfg_we && (state_reg == IDLE);
  assign sweep_last = (idx_reg == CHW'(NCH - 1));

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [CW-1:0] count_reg;
      logic [CW-1:0] period_reg;
      logic          periodic_reg;
      logic          active_reg;
      logic          wr_sel;
      logic          proc_sel;

      assign wr_sel         = cfg_accept && (i_cfg_ch == CHW'(gi));
      assign proc_sel       = (state_reg == SWEEP) && (idx_reg == CHW'(gi));
      assign expire_hit[gi] = proc_sel && active_reg && (count_reg == CW'(1));

      // Writes only land in IDLE, so they never collide with this channel's sweep slot.
      always_ff @(posedge i_clk_25MHz) begin
        if (!i_reset) begin
          count_reg    <= '0;
          period_reg   <= '0;
          periodic_reg <= 1'b0;
          active_reg   <= 1'b0;
        end else if (wr_sel) begin
          count_reg    <= i_cfg_period;
          period_reg   <= i_cfg_period;
          periodic_reg <= i_cfg_periodic;
          active_reg   <= (i_cfg_period != '0);
        end else if (proc_sel && active_reg) begin
          if (count_reg == CW'(1)) begin
            if (periodic_reg) begin
              count_reg <= period_reg;
            end else begin
              active_reg <= 1'b0;
            end
          end else begin
            count_reg <= count_reg - CW'(1);
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge i_clk_25MHz) begin
    if (!i_reset) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      o_expire    <= '0;
      o_busy      <= 1'b0;
      o_overrun   <= 1'b0;
      o_cfg_ready <= 1'b1;
    end else begin
      o_expire <= expire_hit;
      case (state_reg)
        IDLE: begin
          if (trigger) begin
            state_reg   <= SWEEP;
            idx_reg     <= '0;
            o_busy      <= 1'b1;
            o_cfg_ready <= 1'b0;
          end
        end
        SWEEP: begin
          if (trigger) begin
            o_overrun <= 1'b1;
          end
          if (sweep_last) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            o_busy      <= 1'b0;
            o_cfg_ready <= 1'b1;
          end else begin
            idx_reg <= idx_reg + CHW'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Scoreboard bench for tick_scheduler: the stimulus side predicts each sweep's strobes from a trigger-count
// model and queues them; a negedge monitor pops one entry per observed sweep and compares.
`timescale 1ns/1ps

module tb_tick_scheduler;
  localparam int NCH = 4;
  localparam int CW  = 16;
  localparam int CHW = 2;

  logic           i_clk_25MHz = 1'b0;
  logic           i_reset = 1'b0;
  logic           i_tick = 1'b0;
  logic           i_cfg_we = 1'b0;
  logic [CHW-1:0] i_cfg_ch = '0;
  logic [CW-1:0]  i_cfg_period = '0;
  logic           i_cfg_periodic = 1'b0;
  logic           o_cfg_ready;
  logic [NCH-1:0] o_expire;
  logic           o_busy;
  logic           o_overrun;

  tick_scheduler #(.NCH(NCH), .CW(CW), .CHW(CHW)) dut (
    .i_clk_25MHz   (i_clk_25MHz),
    .i_reset       (i_reset),
    .i_tick        (i_tick),
    .i_cfg_we      (i_cfg_we),
    .i_cfg_ch      (i_cfg_ch),
    .i_cfg_period  (i_cfg_period),
    .i_cfg_periodic(i_cfg_periodic),
    .o_cfg_ready   (o_cfg_ready),
    .o_expire      (o_expire),
    .o_busy        (o_busy),
    .o_overrun     (o_overrun)
  );

  always #20 i_clk_25MHz = ~i_clk_25MHz;

  typedef struct {
    logic [NCH-1:0] vec;
    bit             ovr;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: each channel remembers the trigger number on which it next expires.
  int  trig_count = 0;
  int  m_next[NCH];
  int  m_per[NCH];
  bit  m_perd[NCH];
  bit  m_act[NCH];
  bit  m_ovr = 0;
  int  m_presc = 0;
  int  s_now = 0;
  int  sweep_end = -1000;
  bit  last_acc = 0;

  task automatic m_reset();
    for (int c = 0; c < NCH; c++) begin
      m_act[c] = 0; m_per[c] = 0; m_perd[c] = 0; m_next[c] = 0;
    end
    m_ovr = 0;
    m_presc = 0;
    sweep_end = -1000;
    q.delete();
  endtask

  task automatic m_write(input int ch, input int per, input bit perd);
    m_per[ch]  = per;
    m_perd[ch] = perd;
    m_act[ch]  = (per != 0);
    m_next[ch] = trig_count + per;
  endtask

  task automatic m_trigger();
    exp_t e;
    trig_count++;
    e.vec = '0;
    for (int c = 0; c < NCH; c++) begin
      if (m_act[c] && m_next[c] == trig_count) begin
        e.vec[c] = 1'b1;
        if (m_perd[c]) m_next[c] = m_next[c] + m_per[c];
        else           m_act[c] = 0;
      end
    end
    e.ovr = m_ovr;
    q.push_back(e);
  endtask

  // One clock: drive inputs, update the model for the edge that samples them, advance.
  task automatic step(input bit tk, input bit we, input int ch, input int per, input bit perd);
    bit trig;
    last_acc       = 0;
    i_tick         = tk;
    i_cfg_we       = we;
    i_cfg_ch       = ch[CHW-1:0];
    i_cfg_period   = per[CW-1:0];
    i_cfg_periodic = perd;
    if (!i_reset) begin
      m_reset();
    end else begin
      if (we && s_now > sweep_end) begin
        m_write(ch, per, perd);
        last_acc = 1;
      end
      if (tk) begin
        trig = 1;
`ifdef TICK_SCHED_MS_EN
        trig = (m_presc == 999);
        m_presc = (m_presc == 999) ? 0 : m_presc + 1;
`endif
        if (trig) begin
          if (s_now <= sweep_end) begin
            m_ovr = 1;
          end else begin
            m_trigger();
            sweep_end = s_now + NCH;
          end
        end
      end
    end
    @(posedge i_clk_25MHz);
    s_now++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
  endtask

  task automatic tick_gap(input int gap);
    step(1, 0, 0, 0, 0);
    idle(gap - 1);
  endtask

  task automatic write_hold(input int ch, input int per, input bit perd);
    int tries = 0;
    do begin
      step(0, 1, ch, per, perd);
      tries++;
    end while (!last_acc && tries < 40);
    if (!last_acc) begin
      miscompares++;
      $display("FAIL write_hold: write to ch%0d not accepted within %0d cycles, required acceptance", ch, tries);
    end
  endtask

  // Monitor: sampled on the falling edge, one scoreboard pop per sweep.
  bit             rst_q = 0;
  bit             mon_en = 0;
  bit             in_sw = 0;
  bit             prev_busy = 0;
  int             off = 0;
  logic [NCH-1:0] acc, stray, sel, exp_vec;

  always @(posedge i_clk_25MHz) rst_q <= !i_reset;

  always @(negedge i_clk_25MHz) begin
    if (rst_q) begin
      mon_en = 1; in_sw = 0; prev_busy = 0;
      vectors++;
      if (o_expire !== '0 || o_busy !== 1'b0 || o_overrun !== 1'b0 || o_cfg_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_values: got expire=%b busy=%b overrun=%b ready=%b, required 0000 0 0 1",
                 o_expire, o_busy, o_overrun, o_cfg_ready);
      end
    end else if (mon_en) begin
      vectors++;
      if (o_cfg_ready !== ~o_busy) begin
        miscompares++;
        $display("FAIL ready_vs_busy: got ready=%b busy=%b, required ready = !busy", o_cfg_ready, o_busy);
      end
      if (o_busy === 1'b1 && !prev_busy) begin
        in_sw = 1; off = 0; acc = '0; stray = '0;
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          exp_vec = '0;
          $display("FAIL unexpected_sweep: got busy=1 at %0t, required no sweep", $time);
        end else begin
          exp_t e;
          e = q.pop_front();
          exp_vec = e.vec;
          if (o_overrun !== e.ovr) begin
            miscompares++;
            $display("FAIL overrun: got %b, required %b", o_overrun, e.ovr);
          end
        end
      end else if (in_sw) begin
        off++;
      end
      if (in_sw) begin
        sel = '0;
        if (off >= 1 && off <= NCH) sel[off-1] = 1'b1;
        acc   = acc | (o_expire & sel);
        stray = stray | (o_expire & ~sel);
        if (o_busy !== 1'b1 || off > NCH) begin
          vectors++;
          $display("sweep @%0t: expire=%b want=%b len=%0d", $time, acc, exp_vec, off);
          if (acc !== exp_vec || stray !== '0 || off != NCH) begin
            miscompares++;
            $display("FAIL sweep_expire: got strobes=%b stray=%b len=%0d, required %b stray=0000 len=%0d",
                     acc, stray, off, exp_vec, NCH);
          end
          in_sw = 0;
        end
      end else begin
        vectors++;
        if (o_expire !== '0) begin
          miscompares++;
          $display("FAIL idle_strobe: got expire=%b outside a sweep, required 0000", o_expire);
        end
      end
      prev_busy = (o_busy === 1'b1);
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    m_reset();
    i_reset = 1'b0;
    idle(3);
    i_reset = 1'b1;

    for (int k = 0; k < 100; k++) tick_gap(36);

    // Ch0 one-shot period 3, written between ticks.
    idle(5);
    step(0, 1, 0, 3, 0);
    for (int k = 0; k < 5; k++) tick_gap(36);

    // Ch2 periodic period 5 for 20 ticks, then disabled.
    write_hold(2, 5, 1);
    for (int k = 0; k < 20; k++) tick_gap(36);
    write_hold(2, 0, 0);
    for (int k = 0; k < 6; k++) tick_gap(36);

    // Ch1 write raised mid-sweep and held until accepted.
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    write_hold(1, 4, 1);
    idle(20);
    for (int k = 0; k < 9; k++) tick_gap(36);
    write_hold(1, 0, 0);

    // Ch0 period 2 written on the tick cycle, then a tick injected mid-sweep.
    step(1, 1, 0, 2, 0);
    idle(35);
    for (int k = 0; k < 2; k++) tick_gap(36);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    idle(30);
    for (int k = 0; k < 3; k++) tick_gap(36);

    // Reset while idx=1 is being processed with ch3 due on this sweep.
    write_hold(3, 2, 0);
    tick_gap(36);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    i_reset = 1'b0;
    idle(2);
    i_reset = 1'b1;
    for (int k = 0; k < 4; k++) tick_gap(36);

    // Random mix of writes, coincident writes and tick spacings (short gaps drop triggers).
    for (int k = 0; k < 250; k++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 3) begin
        write_hold($urandom_range(0, NCH - 1), $urandom_range(0, 6), 1'($urandom_range(0, 1)));
      end else if (r == 3) begin
        step(1, 1, $urandom_range(0, NCH - 1), $urandom_range(0, 6), 1'($urandom_range(0, 1)));
        idle($urandom_range(NCH + 1, 12));
      end else begin
        tick_gap($urandom_range(2, 14));
      end
    end

    idle(NCH + 4);
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_sweeps: got %0d unobserved sweeps, required 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
